// File: rtl/wave_gen.sv
// Multi-channel periodic waveform generator (saw / triangle / square) on a simple
// valid/ready register bus. One wave_gen_ch instance per channel.

module wave_gen_ch #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr,
  input  logic [1:0]       sel,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      wdata,
  input  logic             sync,
  output logic [31:0]      period,
  output logic [1:0]       mode,
  output logic [OUT_W-1:0] duty,
  output logic [OUT_W-1:0] sample
);
  localparam logic [OUT_W-1:0] PMAX = '1;

  logic [31:0]      presc, period_nx;
  logic [OUT_W-1:0] phase, phase_nx, duty_nx;
  logic             dir_up, dir_nx, restart, idle;

  assign restart = (wr && sel != 2'd3) || sync;
  assign idle    = (mode == 2'd0) || (period == 32'd0);

  always_comb begin
    for (int i = 0; i < 32; i++)    period_nx[i] = wstrb[i/8] ? wdata[i] : period[i];
    for (int i = 0; i < OUT_W; i++) duty_nx[i]   = wstrb[i/8] ? wdata[i] : duty[i];
  end

  // Triangle flips direction at the endpoints without repeating them.
  always_comb begin
    phase_nx = phase + 1'b1;
    dir_nx   = dir_up;
    if (mode == 2'd2) begin
      if (dir_up && phase == PMAX) begin
        phase_nx = phase - 1'b1;
        dir_nx   = 1'b0;
      end else if (!dir_up && phase == '0) begin
        dir_nx   = 1'b1;
      end else if (!dir_up) begin
        phase_nx = phase - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      period <= '0;
      mode   <= '0;
      duty   <= '0;
      presc  <= '0;
      phase  <= '0;
      dir_up <= 1'b1;
      sample <= '0;
    end else begin
      if (wr && sel == 2'd0) period <= period_nx;
      if (wr && sel == 2'd1 && wstrb[0]) mode <= wdata[1:0];
      if (wr && sel == 2'd2) duty <= duty_nx;
      // Restart has priority over a coinciding step.
      if (restart || idle) begin
        presc  <= '0;
        phase  <= '0;
        dir_up <= 1'b1;
        sample <= '0;
      end else if (presc == period) begin
        presc  <= '0;
        phase  <= phase_nx;
        dir_up <= dir_nx;
        if (mode == 2'd3) sample <= (phase_nx < duty) ? PMAX : '0;
        else              sample <= phase_nx;
      end else begin
        presc <= presc + 32'd1;
      end
    end
  end
endmodule

module wave_gen #(
  parameter int NCH   = 4,
  parameter int OUT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 valid,
  output logic                 ready,
  input  logic [3:0]           wstrb,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic [NCH*OUT_W-1:0] out
);
  logic                        accept, is_wr, sync_wr;
  logic [1:0]                  sel;
  logic [3:0]                  chn;
  logic [31:0]                 rd_val;
  logic [NCH-1:0]              ch_wr, ch_sync;
  logic [NCH-1:0][31:0]        period;
  logic [NCH-1:0][1:0]         mode;
  logic [NCH-1:0][OUT_W-1:0]   duty, samp;
  logic                        unused_addr;

  assign accept      = valid && !ready;
  assign is_wr       = |wstrb;
  assign sel         = addr[3:2];
  assign chn         = addr[7:4];
  assign sync_wr     = accept && is_wr && chn == 4'hF && sel == 2'd0;
  assign unused_addr = ^{addr[31:8], addr[1:0]};
  assign out         = samp;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign ch_wr[c]   = accept && is_wr && chn == 4'(c);
    assign ch_sync[c] = sync_wr && wdata[c];
    wave_gen_ch #(.OUT_W(OUT_W)) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .wr     (ch_wr[c]),
      .sel    (sel),
      .wstrb  (wstrb),
      .wdata  (wdata),
      .sync   (ch_sync[c]),
      .period (period[c]),
      .mode   (mode[c]),
      .duty   (duty[c]),
      .sample (samp[c])
    );
  end

  // Global page and unmapped channels fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chn == 4'(c)) begin
        case (sel)
          2'd0:    rd_val = period[c];
          2'd1:    rd_val = {30'b0, mode[c]};
          2'd2:    rd_val = 32'(duty[c]);
          default: rd_val = 32'(samp[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= accept;
      rdata <= (accept && !is_wr) ? rd_val : '0;
    end
  end
endmodule

// File: tb/tb_wave_gen.sv
// Scoreboard bench for wave_gen: expected bus reads and per-cycle samples are queued
// from a reference model, then popped and compared against the DUT.

module tb_wave_gen;
  localparam int NCH = 4, OUT_W = 8;

  logic clk = 0, resetn = 0, valid = 0, ready;
  logic [3:0] wstrb = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [NCH*OUT_W-1:0] out;
  int checks = 0, passed = 0, cyc = 0;
  int t_e0, t_e1, t_es;
  logic [31:0] sb[$];

  wave_gen #(.NCH(NCH), .OUT_W(OUT_W)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .out(out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ch(input int c);
    return 32'(out[c*OUT_W +: OUT_W]);
  endfunction

  function automatic logic [31:0] wave(input int mode, input int steps, input int duty);
    int p;
    case (mode)
      1: return 32'(steps % 256);
      2: begin p = steps % 510; return 32'((p <= 255) ? p : 510 - p); end
      3: begin
        if (steps == 0) return 0;
        p = steps % 256;
        return (p < duty) ? 32'd255 : 32'd0;
      end
      default: return 0;
    endcase
  endfunction

  // Returns at 1ns after the acceptance edge; e is that edge's index.
  task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output int e);
    int n = 0;
    @(negedge clk);
    valid = 1; addr = a; wstrb = s; wdata = d;
    do begin @(posedge clk); #1; n++; end while (ready !== 1'b1 && n < 8);
    checks++;
    if (ready !== 1'b1) $display("FAIL ready_timeout: ready=%b required 1 addr=%h", ready, a);
    else passed++;
    rd = rdata; e = cyc;
    valid = 0; wstrb = 0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp;
    int e;
    valid = 1; addr = 0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0 || rdata !== 32'd0 || out !== '0)
        $display("FAIL reset_state: ready=%b rdata=%h out=%h required 0/0/0", ready, rdata, out);
      else passed++;
    end
    @(negedge clk); valid = 0; resetn = 1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      sb.push_back(32'd0);
      xfer(32'(r * 4), 4'h0, 32'h0, rd, e);
      exp = sb.pop_front();
      checks++;
      if (rd !== exp) $display("FAIL reset_read r%0d: rdata=%h required %h", r, rd, exp);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0 || out !== '0)
        $display("FAIL reset_ready_pulse r%0d: ready=%b out=%h required 0/0", r, ready, out);
      else passed++;
    end
  endtask

  task automatic test_saw();
    logic [31:0] rd, exp;
    int e;
    xfer(32'h00, 4'hF, 32'd2, rd, e);
    xfer(32'h04, 4'hF, 32'd1, rd, t_e0);
    for (int k = 0; k < 774; k++) sb.push_back(wave(1, k / 3, 0));
    for (int k = 0; k < 774; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp = sb.pop_front();
      checks++;
      if (ch(0) !== exp) $display("FAIL saw k=%0d: out=%0d required %0d", k, ch(0), exp);
      else passed++;
    end
  endtask

  task automatic test_triangle();
    logic [31:0] rd, exp;
    int e;
    xfer(32'h10, 4'hF, 32'd0, rd, e);
    xfer(32'h14, 4'hF, 32'd2, rd, e);
    for (int k = 0; k < 20; k++) sb.push_back(32'd0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if (ch(1) !== exp) $display("FAIL tri_idle k=%0d: out=%0d required %0d", k, ch(1), exp);
      else passed++;
    end
    xfer(32'h10, 4'hF, 32'd1, rd, t_e1);
    for (int k = 0; k < 1100; k++) sb.push_back(wave(2, k / 2, 0));
    for (int k = 0; k < 1100; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp = sb.pop_front();
      checks++;
      if (ch(1) !== exp) $display("FAIL tri k=%0d: out=%0d required %0d", k, ch(1), exp);
      else passed++;
    end
  endtask

  task automatic test_square();
    logic [31:0] rd, exp;
    int e;
    xfer(32'h24, 4'hF, 32'd3, rd, e);
    xfer(32'h28, 4'hF, 32'd64, rd, e);
    xfer(32'h20, 4'hF, 32'd0, rd, e);
    xfer(32'h20, 4'hF, 32'd1, rd, e);
    for (int k = 0; k < 1030; k++) sb.push_back(wave(3, k / 2, 64));
    for (int k = 0; k < 1030; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp = sb.pop_front();
      checks++;
      if (ch(2) !== exp) $display("FAIL square k=%0d: out=%0d required %0d", k, ch(2), exp);
      else passed++;
    end
    xfer(32'h28, 4'hF, 32'd0, rd, e);
    for (int k = 0; k < 600; k++) sb.push_back(32'd0);
    for (int k = 0; k < 600; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp = sb.pop_front();
      checks++;
      if (ch(2) !== exp) $display("FAIL square_duty0 k=%0d: out=%0d required %0d", k, ch(2), exp);
      else passed++;
    end
  endtask

  task automatic test_sync();
    logic [31:0] rd, e0, e3, e1;
    int e;
    xfer(32'h30, 4'hF, 32'd2, rd, e);
    xfer(32'h34, 4'hF, 32'd1, rd, e);
    repeat (4) begin @(posedge clk); #1; end
    xfer(32'hF0, 4'hF, 32'h9, rd, t_es);
    for (int k = 0; k < 120; k++) begin
      sb.push_back(wave(1, k / 3, 0));
      sb.push_back(wave(2, (t_es + k - t_e1) / 2, 0));
    end
    for (int k = 0; k < 120; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      e0 = sb.pop_front(); e1 = sb.pop_front(); e3 = e0;
      checks++;
      if (ch(0) !== e0 || ch(3) !== e3)
        $display("FAIL sync k=%0d: ch0=%0d ch3=%0d required %0d", k, ch(0), ch(3), e0);
      else passed++;
      checks++;
      if (ch(1) !== e1) $display("FAIL sync_other k=%0d: ch1=%0d required %0d", k, ch(1), e1);
      else passed++;
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd, exp;
    logic [31:0] a[7];
    logic [3:0]  s[7];
    logic [31:0] d[7];
    int e;
    xfer(32'h30, 4'hF, 32'd0, rd, e);
    xfer(32'h30, 4'b0010, 32'h0000AB00, rd, e);
    checks++;
    if (ch(3) !== 0 || ch(0) !== wave(1, (cyc - t_es) / 3, 0))
      $display("FAIL strobe_restart: ch3=%0d ch0=%0d required 0/%0d", ch(3), ch(0), wave(1, (cyc - t_es) / 3, 0));
    else passed++;
    // Write-then-read table; expected read values queued as each pair is driven.
    a = '{32'h30, 32'h30, 32'h0C, 32'h24, 32'h28, 32'h40, 32'hF4};
    s = '{4'h0, 4'b0101, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    d = '{32'h0, 32'h33CC11DD, 32'h5A, 32'hFFFFFFF6, 32'hFFFFFF80, 32'h77, 32'h1};
    for (int i = 0; i < 7; i++) begin
      if (s[i] != 0) xfer(a[i], s[i], d[i], rd, e);
      case (i)
        0: sb.push_back(32'h0000AB00);
        1: sb.push_back(32'h00CCABDD);
        2: sb.push_back(wave(1, (cyc - t_es) / 3, 0));
        3: sb.push_back(32'd2);
        4: sb.push_back(32'h80);
        5: sb.push_back(32'd0);
        default: sb.push_back(32'd0);
      endcase
      xfer(a[i], 4'h0, 32'h0, rd, e);
      exp = sb.pop_front();
      checks++;
      if (rd !== exp) $display("FAIL strobe_read%0d addr=%h: rdata=%h required %h", i, a[i], rd, exp);
      else passed++;
    end
    sb.push_back(32'd2);
    xfer(32'h00, 4'h0, 32'h0, rd, e);
    exp = sb.pop_front();
    checks++;
    if (rd !== exp) $display("FAIL unmapped_write_leak: ch0 period=%h required %h", rd, exp);
    else passed++;
    sb.push_back(32'd0);
    xfer(32'hF0, 4'h0, 32'h0, rd, e);
    exp = sb.pop_front();
    checks++;
    if (rd !== exp) $display("FAIL sync_read: rdata=%h required %h", rd, exp);
    else passed++;
    checks++;
    if (ch(0) !== wave(1, (cyc - t_es) / 3, 0))
      $display("FAIL status_write_restart: ch0=%0d required %0d", ch(0), wave(1, (cyc - t_es) / 3, 0));
    else passed++;
  endtask

  task automatic test_back_to_back();
    int pulses = 0, n = 0;
    logic [31:0] exp;
    @(negedge clk);
    valid = 1; addr = 32'h00; wstrb = 0;
    for (int k = 0; k < 3; k++) sb.push_back(32'd2);
    repeat (6) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        pulses++;
        exp = sb.pop_front();
        checks++;
        if (rdata !== exp) $display("FAIL b2b_rdata: rdata=%h required %h", rdata, exp);
        else passed++;
      end
    end
    valid = 0;
    n = sb.size();
    sb.delete();
    checks++;
    if (pulses !== 3 || n !== 0) $display("FAIL b2b_rate: pulses=%0d required 3", pulses);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_saw();
    test_triangle();
    test_square();
    test_sync();
    test_strobe();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded, required completion");
    $fatal(1);
  end
endmodule
